// File: rtl/safe_access_arbiter.sv
// Round-robin arbiter sharing one digital_safe code-entry port between N_REQ keypad requesters.
// Holds the granted code on the safe for EVAL_CYCLES, returns the sampled result, and enforces a post-alert lockout.
module safe_access_arbiter #(
    parameter int N_REQ          = 2,
    parameter int CODE_W         = 32,
    parameter int EVAL_CYCLES    = 2,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*CODE_W-1:0] req_code,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic                    resp_unlocked,
    output logic                    resp_alert,
    output logic [CODE_W-1:0]       safe_code,
    input  logic                    safe_unlocked,
    input  logic                    safe_alert,
    output logic                    busy,
    output logic                    locked_out
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int CNT_MAX = (EVAL_CYCLES > LOCKOUT_CYCLES) ? EVAL_CYCLES : LOCKOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] EVAL_LD = CNT_W'(EVAL_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W:0]   N_EXT   = (PTR_W+1)'(N_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RESP    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                unl_q, unl_d;
    logic                alr_q, alr_d;

    logic                found;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W:0]      probe;
    logic [PTR_W:0]      next_ptr;

    // Search downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        probe  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            probe = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (probe >= N_EXT) probe = probe - N_EXT;
            if (req_valid[probe[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = probe[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        next_ptr = {1'b0, winner} + (PTR_W+1)'(1);
        if (next_ptr == N_EXT) next_ptr = '0;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        unl_d      = unl_q;
        alr_d      = alr_q;
        req_ready  = '0;
        resp_valid = '0;
        safe_code  = '0;
        busy       = 1'b1;
        locked_out = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                // Handshake is suppressed while rst is high so no code is taken on a reset edge.
                if (found && !rst) begin
                    req_ready[winner] = 1'b1;
                    grant_d  = winner;
                    code_d   = req_code[winner*CODE_W +: CODE_W];
                    rr_ptr_d = next_ptr[PTR_W-1:0];
                    cnt_d    = EVAL_LD;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                safe_code = code_q;
                cnt_d     = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    unl_d   = safe_unlocked;
                    alr_d   = safe_alert;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid[grant_q] = 1'b1;
                if (alr_q) begin
                    cnt_d   = LOCK_LD;
                    state_d = LOCKOUT;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                locked_out = 1'b1;
                cnt_d      = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_unlocked = unl_q;
    assign resp_alert    = alr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
            unl_q    <= 1'b0;
            alr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            unl_q    <= unl_d;
            alr_q    <= alr_d;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_resp_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(resp_valid));

endmodule

// File: tb/tb_safe_access_arbiter.sv
// Randomized bench for safe_access_arbiter: a transaction-timeline model predicts every cycle,
// a scoreboard queue holds expected records and a negedge monitor compares them with the DUT.
module tb_safe_access_arbiter;

    localparam int N    = 2;
    localparam int W    = 32;
    localparam int E    = 2;
    localparam int L    = 16;
    localparam int NCYC = 4000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_code = '0;
    logic [N-1:0]   req_ready, resp_valid;
    logic           resp_unlocked, resp_alert;
    logic [W-1:0]   safe_code;
    logic           safe_unlocked = 1'b0;
    logic           safe_alert = 1'b0;
    logic           busy, locked_out;

    always #5 clk = ~clk;

    safe_access_arbiter #(.N_REQ(N), .CODE_W(W), .EVAL_CYCLES(E), .LOCKOUT_CYCLES(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_unlocked(resp_unlocked), .resp_alert(resp_alert),
        .safe_code(safe_code), .safe_unlocked(safe_unlocked), .safe_alert(safe_alert),
        .busy(busy), .locked_out(locked_out)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] ready;
        logic [N-1:0] rvalid;
        logic [W-1:0] code;
        logic         lock;
        logic         bsy;
        logic         unl;
        logic         alr;
    } rec_t;

    typedef struct {
        int   cyc;
        int   idx;
        logic unl;
        logic alr;
    } resp_t;

    rec_t  cq[$];
    resp_t rq[$];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, plus a response entry whenever a strobe appears.
    always @(negedge clk) begin
        rec_t  r;
        resp_t p;
        if (cq.size() > 0) begin
            r = cq.pop_front();
            chk("req_ready",     r.cyc, 32'(req_ready),     32'(r.ready));
            chk("resp_valid",    r.cyc, 32'(resp_valid),    32'(r.rvalid));
            chk("safe_code",     r.cyc, safe_code,          r.code);
            chk("locked_out",    r.cyc, 32'(locked_out),    32'(r.lock));
            chk("busy",          r.cyc, 32'(busy),          32'(r.bsy));
            chk("resp_unlocked", r.cyc, 32'(resp_unlocked), 32'(r.unl));
            chk("resp_alert",    r.cyc, 32'(resp_alert),    32'(r.alr));
            if (resp_valid != '0) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", r.cyc, 32'(resp_valid), 32'd0);
                end else begin
                    p = rq.pop_front();
                    chk("resp_cycle",    r.cyc, r.cyc,               p.cyc);
                    chk("resp_owner",    r.cyc, 32'(resp_valid),     32'(1) << p.idx);
                    chk("resp_unl_data", r.cyc, 32'(resp_unlocked),  32'(p.unl));
                    chk("resp_alr_data", r.cyc, 32'(resp_alert),     32'(p.alr));
                end
            end
        end
    end

    // Driver + reference model: a transaction granted in cycle g drives its code in g+1..g+E,
    // responds in g+E+1, and (on alert) locks out g+E+2..g+E+1+L.
    initial begin
        int       busy_until;
        int       g;
        int       cur_idx;
        int       rr;
        int       grant_w;
        int       nrst;
        int       w;
        bit       active;
        bit       rst_now;
        bit       pend [N];
        logic [W-1:0] code [N];
        logic [W-1:0] cur_code;
        logic     cur_unl, cur_alr, last_unl, last_alr;
        rec_t     rec;

        busy_until = 0; g = -100; cur_idx = 0; rr = 0; grant_w = -1; nrst = 0;
        active = 0; cur_code = '0; cur_unl = 0; cur_alr = 0; last_unl = 0; last_alr = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            code[i] = '0;
        end

        for (int c = 1; c <= NCYC; c++) begin
            @(posedge clk);
            #1;
            rst_now = (c <= 2);
            if (c > 2 && active && c == g + 1 && nrst < 6 && $urandom_range(0, 3) == 0) begin
                rst_now = 1;
                nrst++;
            end
            rst = rst_now;

            if (grant_w >= 0) pend[grant_w] = 0;
            grant_w = -1;
            for (int i = 0; i < N; i++) begin
                if (c <= 3 || c > NCYC - 40) begin
                    pend[i] = 0;
                end else if (!pend[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        pend[i] = 1;
                        code[i] = $urandom;
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    pend[i] = 0;
                end
                req_valid[i]       = pend[i];
                req_code[i*W +: W] = code[i];
            end

            rec.cyc    = c;
            rec.ready  = '0;
            rec.rvalid = '0;
            rec.code   = '0;
            rec.lock   = 0;
            rec.bsy    = (c < busy_until);
            if (active) begin
                if (c >= g + 1 && c <= g + E) rec.code = cur_code;
                if (c == g + E + 1) begin
                    rec.rvalid[cur_idx] = 1'b1;
                    last_unl = cur_unl;
                    last_alr = cur_alr;
                end
                if (cur_alr && c >= g + E + 2 && c <= g + E + 1 + L) rec.lock = 1;
            end
            rec.unl = last_unl;
            rec.alr = last_alr;

            // Only the last drive cycle carries the real result; other cycles are noise.
            if (active && c == g + E) begin
                safe_unlocked = cur_unl;
                safe_alert    = cur_alr;
            end else begin
                safe_unlocked = 1'($urandom_range(0, 1));
                safe_alert    = 1'($urandom_range(0, 1));
            end

            if (!rst_now && c >= busy_until) begin
                for (int k = 0; k < N; k++) begin
                    w = (rr + k) % N;
                    if (pend[w] && grant_w < 0) grant_w = w;
                end
                if (grant_w >= 0) begin
                    rec.ready[grant_w] = 1'b1;
                    g          = c;
                    cur_idx    = grant_w;
                    cur_code   = code[grant_w];
                    cur_unl    = 1'($urandom_range(0, 1));
                    cur_alr    = ($urandom_range(0, 4) == 0);
                    busy_until = c + E + 2 + (cur_alr ? L : 0);
                    rr         = (grant_w + 1) % N;
                    active     = 1;
                    rq.push_back('{cyc: c + E + 1, idx: grant_w, unl: cur_unl, alr: cur_alr});
                end
            end

            if (rst_now) begin
                active     = 0;
                busy_until = c + 1;
                rr         = 0;
                last_unl   = 0;
                last_alr   = 0;
                while (rq.size() > 0 && rq[$].cyc > c) void'(rq.pop_back());
            end

            cq.push_back(rec);
        end

        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("resp_queue_drained", NCYC, rq.size(), 0);
        chk("record_queue_drained", NCYC, cq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
